run_control: RTL and testbench

RUN_CONTROL -- requirements
Module: run_control

---
 rtl/run_control.sv | 64 ++++++
 tb/tb_run_control.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/run_control.sv
// Run control for a simple processor core.
// Sequences IDLE -> LOAD -> RUN -> HALTED. It owns the fetch PC and the
// retired-instruction counter, and qualifies retirement with exec_en.
module run_control #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             halt_op,
    input  logic             branch_en,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  PC,
    output logic             exec_en,
    output logic             halt,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state;

    // halt comes only from the state register, so it cannot glitch on inputs.
    // A start request pre-empts retirement in the same cycle.
    assign halt    = (state == IDLE) || (state == HALTED);
    assign exec_en = (state == RUN) && !start;

    // State, PC and counter update; start overrides everything, and the
    // counter saturates instead of wrapping.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            PC         <= '0;
            InstrCount <= '0;
        end else if (start) begin
            state      <= LOAD;
            PC         <= start_addr;
            InstrCount <= '0;
        end else begin
            case (state)
                LOAD: state <= RUN;
                RUN: begin
                    if (InstrCount != {CNT_W{1'b1}})
                        InstrCount <= InstrCount + 1'b1;
                    if (halt_op)
                        state <= HALTED;
                    else if (branch_en)
                        PC <= branch_target;
                    else
                        PC <= PC + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: a vector table for the main sequences,
// hand-written sequences for reset behaviour, and a narrow-counter
// instance for saturation.
module tb_run_control;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic        halt_op = 1'b0;
    logic        branch_en = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [7:0]  PC;
    logic        exec_en;
    logic        halt;
    logic [15:0] InstrCount;

    // second instance with a 4-bit counter so saturation is reachable quickly
    logic        s_start = 1'b0;
    logic [7:0]  s_start_addr = '0;
    logic [7:0]  s_pc;
    logic        s_exec_en;
    logic        s_halt;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    run_control #(.PC_W(8), .CNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .start_addr(start_addr),
        .halt_op(halt_op), .branch_en(branch_en), .branch_target(branch_target),
        .PC(PC), .exec_en(exec_en), .halt(halt), .InstrCount(InstrCount)
    );

    run_control #(.PC_W(8), .CNT_W(4)) dut_sat (
        .CLK(CLK), .Reset(Reset), .start(s_start), .start_addr(s_start_addr),
        .halt_op(1'b0), .branch_en(1'b0), .branch_target(8'h00),
        .PC(s_pc), .exec_en(s_exec_en), .halt(s_halt), .InstrCount(s_cnt)
    );

    typedef struct {
        logic        st;
        logic [7:0]  addr;
        logic        hop;
        logic        br;
        logic [7:0]  tgt;
        logic [7:0]  pc;
        logic        hlt;
        logic        ex;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [7:0] pc,
                           input logic hlt, input logic ex, input logic [15:0] cnt);
        chk({tag, ".pc"},   idx, 32'(PC), 32'(pc));
        chk({tag, ".halt"}, idx, 32'(halt), 32'(hlt));
        chk({tag, ".exec"}, idx, 32'(exec_en), 32'(ex));
        chk({tag, ".cnt"},  idx, 32'(InstrCount), 32'(cnt));
    endtask

    initial begin
        // st addr hop br tgt | pc hlt ex cnt  (expected just after the edge,
        // with the same inputs still applied)
        vecs[0]  = '{1'b1, 8'h68, 1'b0, 1'b0, 8'h00, 8'h68, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h68, 1'b0, 1'b1, 16'd0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h69, 1'b0, 1'b1, 16'd1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h6A, 1'b0, 1'b1, 16'd2};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h6B, 1'b0, 1'b1, 16'd3};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h6C, 1'b0, 1'b1, 16'd4};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h6D, 1'b0, 1'b1, 16'd5};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h6D, 1'b1, 1'b0, 16'd6};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 8'h6D, 1'b1, 1'b0, 16'd6};
        vecs[9]  = '{1'b1, 8'h4B, 1'b0, 1'b0, 8'h00, 8'h4B, 1'b0, 1'b0, 16'd0};
        vecs[10] = '{1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0, 16'd0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b1, 16'd0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 16'd1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'd2};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 16'd3};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h01, 1'b1, 1'b0, 16'd4};
        vecs[16] = '{1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 16'd0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 16'd0};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b1, 16'd1};
        vecs[19] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h99, 8'h55, 1'b0, 1'b0, 16'd0};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h55, 1'b0, 1'b1, 16'd0};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h56, 1'b0, 1'b1, 16'd1};

        // reset value is visible without any clock edge
        #1;
        chk_all("reset", 0, 8'h00, 1'b1, 1'b0, 16'd0);
        @(negedge CLK);
        Reset = 1'b0;

        // idle after reset: nothing moves
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk_all("idle", i, 8'h00, 1'b1, 1'b0, 16'd0);
        end

        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            start = vecs[i].st;
            start_addr = vecs[i].addr;
            halt_op = vecs[i].hop;
            branch_en = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(posedge CLK); #1;
            chk_all("vec", i, vecs[i].pc, vecs[i].hlt, vecs[i].ex, vecs[i].cnt);
        end

        // asynchronous reset mid-run, between edges
        @(negedge CLK);
        start = 1'b0; halt_op = 1'b0; branch_en = 1'b0;
        #1 Reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 8'h00, 1'b1, 1'b0, 16'd0);
        @(negedge CLK);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk_all("post_rst_idle", i, 8'h00, 1'b1, 1'b0, 16'd0);
        end

        // reset released while start is already high
        @(negedge CLK);
        Reset = 1'b1;
        start = 1'b1; start_addr = 8'h77;
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK); #1;
        chk_all("rst_start", 0, 8'h77, 1'b0, 1'b0, 16'd0);
        @(negedge CLK);
        start = 1'b0;
        @(posedge CLK); #1;
        chk_all("rst_start", 1, 8'h77, 1'b0, 1'b1, 16'd0);

        // saturation on the 4-bit counter instance; PC keeps moving and wraps
        @(negedge CLK);
        s_start = 1'b1; s_start_addr = 8'hF0;
        @(posedge CLK); #1;
        chk("sat.pc", 0, 32'(s_pc), 32'h0F0);
        chk("sat.halt", 0, 32'(s_halt), 32'd0);
        @(negedge CLK);
        s_start = 1'b0;
        @(posedge CLK); #1;
        chk("sat.exec", 0, 32'(s_exec_en), 32'd1);
        for (int k = 1; k <= 18; k++) begin
            @(posedge CLK); #1;
            chk("sat.cnt", k, 32'(s_cnt), (k > 15) ? 32'd15 : 32'(k));
            chk("sat.pc", k, 32'(s_pc), 32'((8'hF0 + k) & 8'hFF));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
